sparse_poly_mult_dummy: RTL

//  Next-gen crypto core for the CW305 target: c = a*h mod (x^N-1) over GF(2).
//  a is dense (data_i); h is sparse, given as W bit positions (key_i).

---
 rtl/polymult_pkg.sv | 41 ++++
 rtl/sparse_poly_mult_dummy_if.sv | 23 ++
 rtl/poly_rot_barrel.sv | 22 ++
 rtl/sparse_poly_mult_dummy.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/polymult_pkg.sv
// Shared constants, state encodings and key-field helpers for the sparse
// GF(2) polynomial multiplier with shuffled dummy slots.
package polymult_pkg;

  localparam int N         = 128;
  localparam int W         = 8;
  localparam int D         = 8;
  localparam int T         = W + D;
  localparam int IDXW      = $clog2(N);
  localparam int SEED_W    = 16;
  localparam int KEY_WIDTH = 128;
  localparam int KW        = $clog2(W);
  localparam int CNTW      = $clog2(((W > D) ? W : D) + 1);

  // Taps for x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form
  localparam logic [SEED_W-1:0] LFSR_TAPS    = 16'h002D;
  localparam logic [SEED_W-1:0] DEFAULT_SEED = 16'hACE1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  typedef logic [IDXW-1:0] pos_t;

  function automatic int pos_lsb(input int j);
    return j * IDXW;
  endfunction

  function automatic int seed_lsb();
    return KEY_WIDTH - SEED_W;
  endfunction

  function automatic int dummy_en_bit();
    return KEY_WIDTH - SEED_W - 1;
  endfunction

  function automatic logic [SEED_W-1:0] lfsr_step(input logic [SEED_W-1:0] s);
    return {^(s & LFSR_TAPS), s[SEED_W-1:1]};
  endfunction

endpackage

// File: rtl/sparse_poly_mult_dummy_if.sv
// Load/busy block interface of the poly-mult cores, plus the slot-trace probe.
interface sparse_poly_mult_dummy_if;
  import polymult_pkg::*;

  logic                 load_i;
  logic [KEY_WIDTH-1:0] key_i;
  logic [N-1:0]         data_i;
  logic [N-1:0]         data_o;
  logic                 busy_o;
  logic                 done_o;
  logic [T-1:0]         slot_trace_o;

  modport master (
    output load_i, key_i, data_i,
    input  data_o, busy_o, done_o, slot_trace_o
  );

  modport slave (
    input  load_i, key_i, data_i,
    output data_o, busy_o, done_o, slot_trace_o
  );

endinterface

// File: rtl/poly_rot_barrel.sv
// Combinational N-bit rotate-left by an IDXW-bit amount, one mux stage per
// amount bit.
module poly_rot_barrel
  import polymult_pkg::*;
(
  input  logic [N-1:0] din,
  input  pos_t         amt,
  output logic [N-1:0] dout
);

  logic [N-1:0] stage_s;

  // Stage s rotates by 2**s when amt[s] is set; bits leaving the top re-enter at bit 0.
  always_comb begin
    stage_s = din;
    for (int s = 0; s < IDXW; s++) begin
      stage_s = amt[s] ? ((stage_s << (1 << s)) | (stage_s >> (N - (1 << s)))) : stage_s;
    end
    dout = stage_s;
  end

endmodule

// File: rtl/sparse_poly_mult_dummy.sv
// c = a*h mod (x^N-1) over GF(2) with h sparse; W real and D dummy
// rotate-XOR slots run in an LFSR-shuffled order with a fixed cycle count.
module sparse_poly_mult_dummy
  import polymult_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_i,
  sparse_poly_mult_dummy_if.slave  bus
);

  localparam logic [CNTW-1:0] CNT_ZERO = CNTW'(0);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_W    = CNTW'(W);
  localparam logic [CNTW-1:0] CNT_D    = CNTW'(D);

  logic [1:0]        state_r;
  logic [N-1:0]      a_r;
  logic [N-1:0]      acc_r;
  (* keep = "true" *) logic [N-1:0] dacc_r;
  logic [N-1:0]      data_r;
  pos_t              pos_r [W];
  logic [KW-1:0]     k_r;
  logic [SEED_W-1:0] lfsr_r;
  logic              dummy_en_r;
  logic [CNTW-1:0]   rem_real_r;
  logic [CNTW-1:0]   rem_dummy_r;
  logic              busy_r;
  logic              done_r;
  logic [T-1:0]      trace_r;

  logic              slot_real_s;
  logic              last_slot_s;
  pos_t              rot_amt_s;
  logic [N-1:0]      rot_s;
  logic [SEED_W-1:0] seed_s;

  // Slot selection: forced real/dummy once one pool is exhausted, else shuffled.
  always_comb begin
    slot_real_s = 1'b1;
    if (rem_dummy_r == CNT_ZERO) begin
      slot_real_s = 1'b1;
    end else if (rem_real_r == CNT_ZERO) begin
      slot_real_s = 1'b0;
    end else if (!dummy_en_r) begin
      slot_real_s = 1'b1;
    end else begin
      slot_real_s = lfsr_r[0];
    end
  end

  // Final slot of RUN: the pool being consumed has one left and the other is empty.
  always_comb begin
    last_slot_s = 1'b0;
    if (slot_real_s) begin
      last_slot_s = (rem_real_r == CNT_ONE) && (rem_dummy_r == CNT_ZERO);
    end else begin
      last_slot_s = (rem_dummy_r == CNT_ONE) && (rem_real_r == CNT_ZERO);
    end
  end

  // Rotator amount and seed substitution for an all-zero seed.
  always_comb begin
    rot_amt_s = slot_real_s ? pos_r[k_r] : lfsr_r[IDXW:1];
    seed_s    = bus.key_i[seed_lsb() +: SEED_W];
    if (seed_s == {SEED_W{1'b0}}) begin
      seed_s = DEFAULT_SEED;
    end else begin
      seed_s = bus.key_i[seed_lsb() +: SEED_W];
    end
  end

  poly_rot_barrel u_rot (
    .din  (a_r),
    .amt  (rot_amt_s),
    .dout (rot_s)
  );

  // Operation sequencer: capture on load, one slot per RUN cycle, then commit.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= ST_IDLE;
      a_r         <= {N{1'b0}};
      acc_r       <= {N{1'b0}};
      dacc_r      <= {N{1'b0}};
      data_r      <= {N{1'b0}};
      k_r         <= {KW{1'b0}};
      lfsr_r      <= {SEED_W{1'b0}};
      dummy_en_r  <= 1'b0;
      rem_real_r  <= CNT_ZERO;
      rem_dummy_r <= CNT_ZERO;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      trace_r     <= {T{1'b0}};
      for (int j = 0; j < W; j++) begin
        pos_r[j] <= {IDXW{1'b0}};
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.load_i) begin
            a_r         <= bus.data_i;
            acc_r       <= {N{1'b0}};
            dacc_r      <= {N{1'b0}};
            k_r         <= {KW{1'b0}};
            lfsr_r      <= seed_s;
            dummy_en_r  <= bus.key_i[dummy_en_bit()];
            rem_real_r  <= CNT_W;
            rem_dummy_r <= CNT_D;
            trace_r     <= {T{1'b0}};
            busy_r      <= 1'b1;
            state_r     <= ST_RUN;
            for (int j = 0; j < W; j++) begin
              pos_r[j] <= bus.key_i[pos_lsb(j) +: IDXW];
            end
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          done_r <= 1'b0;
          if (slot_real_s) begin
            acc_r      <= acc_r ^ rot_s;
            rem_real_r <= rem_real_r - CNT_ONE;
            k_r        <= k_r + KW'(1);
          end else begin
            dacc_r      <= dacc_r ^ rot_s;
            rem_dummy_r <= rem_dummy_r - CNT_ONE;
          end
          lfsr_r  <= lfsr_step(lfsr_r);
          trace_r <= {slot_real_s, trace_r[T-1:1]};
          if (last_slot_s) begin
            state_r <= ST_COMMIT;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_COMMIT: begin
          data_r  <= acc_r;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.data_o       = data_r;
  assign bus.busy_o       = busy_r;
  assign bus.done_o       = done_r;
  assign bus.slot_trace_o = trace_r;

endmodule
